// File: rtl/mul_add32_if.sv
// Handshake and operand/result bundle for the mul_add32 multiply-accumulate unit.
// The master issues start with q/b/r; the slave returns busy/done/product.
interface mul_add32_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     r;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, q, b, r,
    input  busy, done, product
  );

  modport slave (
    input  start, q, b, r,
    output busy, done, product
  );
endinterface

// File: rtl/mul_add32.sv
// Sequential shift-and-add multiply-accumulate: product = q*b + r.
// One partial product per clock, fixed WIDTH-iteration run, start/busy/done handshake.
module mul_add32 #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_add32_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   acc, mcand, acc_add, product_q;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 last;

  always_comb begin
    acc_add = acc;
    if (mplier[0]) acc_add = acc + mcand;
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured only on an accepted start, so later input changes are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= {{WIDTH{1'b0}}, bus.r};
            mcand  <= {{WIDTH{1'b0}}, bus.b};
            mplier <= bus.q;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) product_q <= acc_add;
        end
        default: ;
      endcase
    end
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_mul_add32.sv
// Scoreboard bench for mul_add32: stimulus pushes expected products, a monitor
// pops and compares on every done pulse.
module tb_mul_add32;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_add32_if #(.WIDTH(W)) bus ();

  mul_add32 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [2*W-1:0] expq[$];

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got product %h expected no done", bus.product);
      end else begin
        logic [2*W-1:0] e;
        e = expq.pop_front();
        if (bus.product !== e) begin
          bad++;
          $display("FAIL product: got %h expected %h", bus.product, e);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  // Issues one op and checks that done appears exactly WIDTH edges after the accepting edge.
  task automatic do_op(input logic [W-1:0] q, input logic [W-1:0] b, input logic [W-1:0] r,
                       input logic [2*W-1:0] exp);
    int n;
    wait_idle();
    @(negedge clk);
    bus.q = q; bus.b = b; bus.r = r; bus.start = 1'b1;
    expq.push_back(exp);
    @(posedge clk); #1;
    n = 0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.q = $urandom; bus.b = $urandom; bus.r = $urandom;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'(W));
  endtask

  initial begin
    logic [W-1:0] a, d, qq, rr, rq, rb, rrr;
    int dc;

    bus.start = 1'b0; bus.q = '0; bus.b = '0; bus.r = '0;
    #12;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_product", bus.product, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic op and busy release.
    do_op(32'd7, 32'd6, 32'd5, 64'd47);
    @(posedge clk); #1;
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    chk("product_hold", bus.product, 64'd47);

    do_op('1, '1, '1, 64'hFFFFFFFF00000000);
    do_op(32'd0, 32'h1234, 32'hABCD, 64'h000000000000ABCD);
    do_op(32'h80000000, 32'd2, 32'd0, 64'h0000000100000000);
    do_op(32'd1, 32'hFFFFFFFF, 32'd0, 64'h00000000FFFFFFFF);
    do_op(32'h10000, 32'h10000, 32'd3, 64'h0000000100000003);

    // start while busy (mid-run and in DONE) is ignored.
    wait_idle();
    dc = done_cnt;
    @(negedge clk);
    bus.q = 32'd3; bus.b = 32'd3; bus.r = 32'd0; bus.start = 1'b1;
    expq.push_back(64'd9);
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.q = 32'd9; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    begin
      int n = 0;
      while (bus.done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    end
    bus.q = 32'd9; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (40) @(negedge clk);
    chk("single_done", 64'(done_cnt - dc), 64'd1);
    chk("product_held", bus.product, 64'd9);
    chk("idle_after_ignored", 64'(bus.busy), 64'd0);

    // Async reset mid-operation aborts without a done pulse.
    dc = done_cnt;
    @(negedge clk);
    bus.q = 32'd5; bus.b = 32'd5; bus.r = 32'd1; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_product", bus.product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - dc), 64'd0);
    do_op(32'd5, 32'd5, 32'd1, 64'd26);

    // Model-checked ops and division round-trip.
    for (int i = 0; i < 12; i++) begin
      rq = $urandom; rb = $urandom; rrr = $urandom;
      do_op(rq, rb, rrr, {32'd0, rq} * {32'd0, rb} + {32'd0, rrr});
    end
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      d = $urandom_range(1, 70000);
      qq = a / d; rr = a % d;
      do_op(qq, d, rr, {32'd0, a});
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
